booth_sequencer: RTL and testbench
==================================

Name: booth_sequencer

Overview:
- Control and datapath sequencer for the radix-2 Booth multiplier.
- Sits directly upstream of the adder stage. It owns the A/Q/Q-1/M registers and the iteration counter.
- Each cycle it drives the adder operands and carry-in, then consumes the adder sum and applies the arithmetic right shift.
- It produces a signed 2*WIDTH-bit product after WIDTH iterations.

Parameters:
- WIDTH, 8, operand width in bits (signed two's complement), minimum 2.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new multiply; sampled only when not busy.
- multiplicand  input  WIDTH  signed M, captured on accepted start.
- multiplier  input  WIDTH  signed Q, captured on accepted start.
- add_a  output  WIDTH+1  adder operand a = current A register.
- add_b  output  WIDTH+1  adder operand b = sign-extended M, ~M_ext, or 0.
- add_cin  output  1  adder carry-in (1 only for subtract).
- add_sum  input  WIDTH+1  adder result, used combinationally the same cycle.
- busy  output  1  high while iterations run.
- done  output  1  one-cycle pulse when product becomes valid.
- product  output  2*WIDTH  signed result, held until the next accepted start or reset.

Behaviour:

Reset (rst=1 at an edge), regardless of state:
- State goes to IDLE.
- busy=0, done=0, product=0.
- A=0, Q=0, Q_1=0, M=0, count=0.

Adder interface:
- The adder is instantiated with WIDTH+1.
- A is WIDTH+1 bits so that M = -2^(WIDTH-1) negates without overflow.
- M_ext is M sign-extended to WIDTH+1 bits.
- Operand selection by {Q[0],Q_1}, combinational from the registers:
  - 01: add_b=M_ext, add_cin=0 (A+M).
  - 10: add_b=~M_ext, add_cin=1 (A-M).
  - 00 or 11: add_b=0, add_cin=0 (sum = A).
- add_a=A in every state.
- In IDLE/DONE, outputs follow the same rule but the sum is ignored.

States:
- IDLE:
  - start=1 -> load A=0, Q=multiplier, Q_1=0, M=multiplicand, count=WIDTH.
  - Go to RUN.
- RUN:
  - Every cycle: {A,Q,Q_1} <= arithmetic shift right by 1 of {add_sum,Q,Q_1}.
  - The MSB of add_sum is replicated into the top bit.
  - count <= count-1.
  - When count==1 this cycle -> go to DONE.
- DONE:
  - Lasts exactly one cycle.
  - done=1; product = lower 2*WIDTH bits of {A,Q}.
  - Next cycle: IDLE. If start=1 in DONE, the start is accepted as in IDLE and the next state is RUN.

Timing:
- Start sampled at edge k -> busy=1 during cycles k+1..k+WIDTH.
- At edge k+WIDTH+1, done=1 for one cycle and product updates.
- Latency from the accepting edge to done is WIDTH+1 cycles.
- Throughput: one multiply per WIDTH+1 cycles with back-to-back starts.
- busy is a registered output: 1 exactly in RUN, 0 in IDLE/DONE.
- done is registered: 1 exactly in DONE.

Boundary conditions:
- start while busy: ignored; operands are not re-sampled and the result is unaffected.
- start held high continuously: back-to-back multiplies; each accepted in IDLE or DONE.
- rst asserted mid-RUN: aborts immediately to the reset values; no done pulse; the partial product is discarded.
- rst and start both high: rst wins.
- Extreme operands: the full product range, including (-2^(W-1))*(-2^(W-1)) = 2^(2W-2), must be exact.
- Changes on multiplicand/multiplier after the start edge: no effect.

Test Plan:
- rst, then start with M=3, Q=-4 (WIDTH=8) -> busy high 8 cycles, done pulse on the 9th edge, product=16'hFFF4 (-12), busy=0.
- M=-128, Q=-128 -> product=16'h4000 (16384); also M=127, Q=-128 -> product=16'hC080 (-16256).
- M=0, Q=-1 and M=-1, Q=-1 -> product=0 then product=1; product holds its value in IDLE until the next start.
- Start M=5, Q=7, pulse start again with M=2, Q=2 in cycle 3 of RUN -> second start ignored, product=35.
- Start M=9, Q=9, assert rst at cycle 4 of RUN -> next cycle busy=0, done=0, product=0, no done pulse later; then a fresh start M=-6, Q=11 -> product=16'hFFBE (-66).
- start held high across two operations (M=10,Q=-3 then M=-7,Q=-7) -> done pulses exactly WIDTH+1 cycles apart, products 16'hFFE2 then 16'h0031.
- Self-checking loop of 1000 random signed pairs against a reference model.

Source files
------------

// File: rtl/booth_sequencer.sv
// Radix-2 Booth multiplier sequencer: owns A/Q/Q-1/M and the iteration counter,
// drives an external WIDTH+1 adder and applies the arithmetic right shift.
module booth_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [WIDTH:0]       add_a,
    output logic [WIDTH:0]       add_b,
    output logic                 add_cin,
    input  logic [WIDTH:0]       add_sum,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [1:0]           state_dbg
);

    // Handshake: start is accepted on a rising edge only while busy=0
    // (IDLE or DONE); while busy=1 it is ignored and operands are not sampled.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] COUNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(1);

    state_t             state;
    logic [WIDTH:0]     a;
    logic [WIDTH-1:0]   q;
    logic               q_1;
    logic [WIDTH-1:0]   m;
    logic [CNT_W-1:0]   count;

    logic [WIDTH:0]     m_ext;
    logic [WIDTH:0]     a_next;
    logic [WIDTH-1:0]   q_next;
    logic               q_1_next;
    logic               accept;

    assign add_a     = a;
    assign state_dbg = state;

    always_comb begin
        m_ext   = {m[WIDTH-1], m};
        add_b   = '0;
        add_cin = 1'b0;
        case ({q[0], q_1})
            2'b01: add_b = m_ext;
            2'b10: begin
                add_b   = ~m_ext;
                add_cin = 1'b1;
            end
            default: add_b = '0;
        endcase
    end

    // Arithmetic shift of {add_sum, Q, Q_1}: the sum's sign bit is replicated.
    assign a_next   = {add_sum[WIDTH], add_sum[WIDTH:1]};
    assign q_next   = {add_sum[0], q[WIDTH-1:1]};
    assign q_1_next = q[0];

    assign accept = start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            a       <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            m       <= '0;
            count   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (accept) begin
                        a     <= '0;
                        q     <= multiplier;
                        q_1   <= 1'b0;
                        m     <= multiplicand;
                        count <= COUNT_INIT;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a     <= a_next;
                    q     <= q_next;
                    q_1   <= q_1_next;
                    count <= count - 1'b1;
                    if (count == COUNT_LAST) begin
                        // Product is captured from the final shift so it is valid with done.
                        product <= {a_next[WIDTH-1:0], q_next};
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_sequencer.sv
// Directed and random checks for booth_sequencer with a behavioural adder
// closing the add_a/add_b/add_cin -> add_sum loop.
module tb_booth_sequencer;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic [W:0]     add_a;
  logic [W:0]     add_b;
  logic           add_cin;
  logic [W:0]     add_sum;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic [1:0]     state_dbg;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0]   m;
    logic [W-1:0]   q;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  booth_sequencer #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_cin      (add_cin),
    .add_sum      (add_sum),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .state_dbg    (state_dbg)
  );

  assign add_sum = add_a + add_b + {{W{1'b0}}, add_cin};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // drivers
  task automatic launch(input logic [W-1:0] m, input logic [W-1:0] q);
    @(negedge clk);
    start = 1'b1;
    multiplicand = m;
    multiplier = q;
    @(negedge clk);
    start = 1'b0;
    multiplicand = ~m;
    multiplier = q ^ 8'h5A;
  endtask

  task automatic wait_done(input string name, input logic [2*W-1:0] exp, input int inject);
    int n;
    int busy_cycles;
    n = 1;
    busy_cycles = 0;
    while (!done && n <= 3 * W) begin
      if (busy) busy_cycles++;
      if (n == inject) begin
        start = 1'b1;
        multiplicand = 8'd2;
        multiplier = 8'd2;
      end else if (n == inject + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({name, "_done_seen"}, done, 1);
    check({name, "_latency"}, n, W + 1);
    check({name, "_busy_cycles"}, busy_cycles, W);
    check({name, "_busy_in_done"}, busy, 0);
    check({name, "_state_done"}, state_dbg, 2);
    check({name, "_product"}, product, exp);
    @(negedge clk);
    check({name, "_done_pulse_width"}, done, 0);
    check({name, "_product_hold"}, product, exp);
  endtask

  // scoreboard-style reference for random pairs
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q);
    logic signed [W-1:0]   ms;
    logic signed [W-1:0]   qs;
    logic signed [2*W-1:0] e;
    ms = m;
    qs = q;
    e = ms * qs;
    return e;
  endfunction

  initial begin
    int n;
    int seen_done;
    logic [W-1:0] rm;
    logic [W-1:0] rq;

    vecs[0] = '{8'h03, 8'hFC, 16'hFFF4};
    vecs[1] = '{8'h80, 8'h80, 16'h4000};
    vecs[2] = '{8'h7F, 8'h80, 16'hC080};
    vecs[3] = '{8'h00, 8'hFF, 16'h0000};
    vecs[4] = '{8'hFF, 8'hFF, 16'h0001};
    vecs[5] = '{8'h7F, 8'h7F, 16'h3F01};
    vecs[6] = '{8'hFF, 8'h80, 16'h0080};
    vecs[7] = '{8'h01, 8'h80, 16'hFF80};
    vecs[8] = '{8'h80, 8'h7F, 16'hC080};
    vecs[9] = '{8'h05, 8'h07, 16'h0023};

    // reset with start also high: reset must win
    rst = 1'b1;
    start = 1'b1;
    multiplicand = 8'h11;
    multiplier = 8'h22;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_product", product, 0);
    check("reset_state", state_dbg, 0);
    check("reset_add_a", add_a, 0);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("idle_after_reset_busy", busy, 0);

    foreach (vecs[i]) begin
      launch(vecs[i].m, vecs[i].q);
      wait_done($sformatf("vec%0d", i), vecs[i].exp, -1);
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d_idle_hold", i), product, vecs[i].exp);
    end

    // start pulsed in cycle 3 of RUN with other operands: ignored
    launch(8'd5, 8'd7);
    wait_done("start_while_busy", 16'd35, 3);
    @(negedge clk);
    check("start_while_busy_no_rerun", busy, 0);

    // reset mid-RUN aborts without a done pulse
    launch(8'd9, 8'd9);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_done", done, 0);
    check("midrun_rst_product", product, 0);
    check("midrun_rst_state", state_dbg, 0);
    seen_done = 0;
    repeat (2 * W) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    check("midrun_rst_no_done", seen_done, 0);
    launch(8'hFA, 8'h0B);
    wait_done("after_rst", 16'hFFBE, -1);

    // start held high: back-to-back, second accepted in DONE
    @(negedge clk);
    start = 1'b1;
    multiplicand = 8'd10;
    multiplier = 8'hFD;
    @(negedge clk);
    multiplicand = 8'hF9;
    multiplier = 8'hF9;
    n = 1;
    while (!done && n <= 3 * W) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_done", done, 1);
    check("b2b_first_latency", n, W + 1);
    check("b2b_first_product", product, 16'hFFE2);
    @(negedge clk);
    check("b2b_reaccept_busy", busy, 1);
    check("b2b_reaccept_done_low", done, 0);
    n = 1;
    while (!done && n <= 3 * W) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("b2b_second_done", done, 1);
    check("b2b_spacing", n, W + 1);
    check("b2b_second_product", product, 16'h0031);
    @(negedge clk);
    check("b2b_stop_busy", busy, 0);
    check("b2b_stop_done", done, 0);

    // random signed pairs against the reference product
    for (int i = 0; i < 1000; i++) begin
      rm = W'($urandom_range(0, (1 << W) - 1));
      rq = W'($urandom_range(0, (1 << W) - 1));
      launch(rm, rq);
      wait_done($sformatf("rand%0d_m%0h_q%0h", i, rm, rq), ref_mul(rm, rq), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
